// File: rtl/pong_pkg.sv
// Shared pong state encodings and screen geometry.
// Paddle instances and the game sequencer take their geometry from here.
package pong_pkg;

    typedef enum logic [2:0] {
        S_Idle  = 3'd0,
        S_Serve = 3'd1,
        S_Play  = 3'd2,
        S_Point = 3'd3,
        S_Over  = 3'd4
    } state_t;

    localparam int ScreenWidth  = 1280;
    localparam int yTopBar      = 100;
    localparam int yBottomBar   = 924;
    localparam int PaddleHeight = 200;
    localparam int PaddleWidth  = 16;
    localparam int xLeftPaddle  = 40;
    localparam int xRightPaddle = 1224;
    localparam int BallSize     = 16;
    localparam int BallStep     = 2;
    localparam int WinScore     = 7;
    localparam int PointDelay   = 60;

    localparam logic [10:0] BallXCentre =
        11'((ScreenWidth - BallSize) / 2);
    localparam logic [10:0] BallYCentre =
        11'((yTopBar + yBottomBar - BallSize) / 2);

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for an active-low key plus falling-edge pulse.
// All flops reset to the released (high) level.
module key_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_key_n;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_press = r_prev & ~r_sync;

endmodule

// File: rtl/pong_ctrl.sv
// Pong game sequencer: ball motion, bounces, scoring and
// the serve / point / game-over flow.
module pong_ctrl
    import pong_pkg::*;
(
    input  logic        GameClock,
    input  logic        Resetn,
    input  logic        Tick,
    input  logic        ServeKey,
    input  logic [10:0] PaddleLY,
    input  logic [10:0] PaddleRY,
    output logic [10:0] BallX,
    output logic [10:0] BallY,
    output logic [3:0]  ScoreL,
    output logic [3:0]  ScoreR,
    output logic        PaddleReset,
    output logic        GameOver,
    output logic [2:0]  State
);

    localparam logic [11:0] C_W    = 12'(ScreenWidth);
    localparam logic [11:0] C_YT   = 12'(yTopBar);
    localparam logic [11:0] C_YB   = 12'(yBottomBar);
    localparam logic [11:0] C_PH   = 12'(PaddleHeight);
    localparam logic [11:0] C_PW   = 12'(PaddleWidth);
    localparam logic [11:0] C_XL   = 12'(xLeftPaddle);
    localparam logic [11:0] C_XR   = 12'(xRightPaddle);
    localparam logic [11:0] C_SIZE = 12'(BallSize);
    localparam logic [11:0] C_STEP = 12'(BallStep);
    localparam logic [3:0]  C_WIN  = 4'(WinScore);
    localparam logic [5:0]  C_DLY  = 6'(PointDelay - 1);

    state_t      r_state,  w_state_nxt;
    logic [10:0] r_ball_x, w_x_nxt;
    logic [10:0] r_ball_y, w_y_nxt;
    logic        r_dx,     w_dx_nxt;
    logic        r_dy,     w_dy_nxt;
    logic [3:0]  r_score_l, w_sl_nxt;
    logic [3:0]  r_score_r, w_sr_nxt;
    logic [5:0]  r_cnt,    w_cnt_nxt;
    logic        r_preset, w_preset_nxt;
    logic        r_over,   w_over_nxt;

    logic        w_press;
    logic [11:0] w_x12, w_y12, w_ly12, w_ry12;
    logic        w_miss_l, w_miss_r;
    logic        w_ovl_l, w_ovl_r;
    logic        w_hit_l, w_hit_r;
    logic        w_wall_b, w_wall_t;
    logic [10:0] w_x_step, w_y_step;

    key_sync_edge u_serve (
        .i_clk   (GameClock),
        .i_rst_n (Resetn),
        .i_key_n (ServeKey),
        .o_press (w_press)
    );

    assign w_x12  = {1'b0, r_ball_x};
    assign w_y12  = {1'b0, r_ball_y};
    assign w_ly12 = {1'b0, PaddleLY};
    assign w_ry12 = {1'b0, PaddleRY};

    assign w_miss_l = ~r_dx & (w_x12 < C_STEP);
    assign w_miss_r = r_dx & (w_x12 + C_SIZE + C_STEP > C_W);

    assign w_ovl_l = (w_y12 + C_SIZE > w_ly12) & (w_y12 < w_ly12 + C_PH);
    assign w_ovl_r = (w_y12 + C_SIZE > w_ry12) & (w_y12 < w_ry12 + C_PH);

    assign w_hit_l = ~r_dx & w_ovl_l
                   & (w_x12 <= C_XL + C_PW)
                   & (w_x12 + C_SIZE > C_XL);
    // Right face is tested against the ball's leading edge after this step.
    assign w_hit_r = r_dx & w_ovl_r
                   & (w_x12 + C_SIZE + C_STEP >= C_XR)
                   & (w_x12 < C_XR + C_PW);

    assign w_wall_b = r_dy & (w_y12 + C_SIZE + C_STEP >= C_YB);
    assign w_wall_t = ~r_dy & (w_y12 <= C_YT + C_STEP);

    assign w_x_step = r_dx ? r_ball_x + 11'(BallStep)
                           : r_ball_x - 11'(BallStep);
    assign w_y_step = r_dy ? r_ball_y + 11'(BallStep)
                           : r_ball_y - 11'(BallStep);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_ball_x;
        w_y_nxt     = r_ball_y;
        w_dx_nxt    = r_dx;
        w_dy_nxt    = r_dy;
        w_sl_nxt    = r_score_l;
        w_sr_nxt    = r_score_r;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_Idle: begin
                if (w_press) w_state_nxt = S_Serve;
            end
            S_Serve: begin
                if (w_press) w_state_nxt = S_Play;
            end
            S_Play: begin
                if (Tick) begin
                    if (w_miss_l) begin
                        if (r_score_r < C_WIN) w_sr_nxt = r_score_r + 4'd1;
                        w_dx_nxt    = 1'b0;
                        w_x_nxt     = BallXCentre;
                        w_y_nxt     = BallYCentre;
                        w_state_nxt = S_Point;
                    end else if (w_miss_r) begin
                        if (r_score_l < C_WIN) w_sl_nxt = r_score_l + 4'd1;
                        w_dx_nxt    = 1'b1;
                        w_x_nxt     = BallXCentre;
                        w_y_nxt     = BallYCentre;
                        w_state_nxt = S_Point;
                    end else begin
                        w_x_nxt = w_x_step;
                        w_y_nxt = w_y_step;
                        if (w_hit_l) begin
                            w_x_nxt  = 11'(xLeftPaddle + PaddleWidth);
                            w_dx_nxt = 1'b1;
                        end else if (w_hit_r) begin
                            w_x_nxt  = 11'(xRightPaddle - BallSize);
                            w_dx_nxt = 1'b0;
                        end
                        if (w_wall_b) begin
                            w_y_nxt  = 11'(yBottomBar - BallSize);
                            w_dy_nxt = 1'b0;
                        end else if (w_wall_t) begin
                            w_y_nxt  = 11'(yTopBar);
                            w_dy_nxt = 1'b1;
                        end
                    end
                end
            end
            S_Point: begin
                if (Tick) begin
                    if (r_cnt == C_DLY) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_score_l == C_WIN ||
                                       r_score_r == C_WIN) ? S_Over : S_Serve;
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end
            end
            S_Over: begin
                if (w_press) begin
                    w_sl_nxt    = '0;
                    w_sr_nxt    = '0;
                    w_dx_nxt    = 1'b1;
                    w_state_nxt = S_Serve;
                end
            end
            default: w_state_nxt = S_Idle;
        endcase
        w_preset_nxt = (w_state_nxt == S_Idle) ||
                       (w_state_nxt == S_Point) ||
                       (w_state_nxt == S_Over);
        w_over_nxt   = (w_state_nxt == S_Over);
    end

    always_ff @(posedge GameClock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= S_Idle;
            r_ball_x  <= BallXCentre;
            r_ball_y  <= BallYCentre;
            r_dx      <= 1'b1;
            r_dy      <= 1'b1;
            r_score_l <= '0;
            r_score_r <= '0;
            r_cnt     <= '0;
            r_preset  <= 1'b1;
            r_over    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ball_x  <= w_x_nxt;
            r_ball_y  <= w_y_nxt;
            r_dx      <= w_dx_nxt;
            r_dy      <= w_dy_nxt;
            r_score_l <= w_sl_nxt;
            r_score_r <= w_sr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_preset  <= w_preset_nxt;
            r_over    <= w_over_nxt;
        end
    end

    assign BallX       = r_ball_x;
    assign BallY       = r_ball_y;
    assign ScoreL      = r_score_l;
    assign ScoreR      = r_score_r;
    assign PaddleReset = r_preset;
    assign GameOver    = r_over;
    assign State       = r_state;

endmodule

// File: tb/tb_pong_ctrl.sv
// Randomized bench for pong_ctrl against a behavioural game model.
// Ball velocity is kept as signed pixels per Tick in the model.
module tb_pong_ctrl;

    logic        GameClock = 1'b0;
    logic        Resetn;
    logic        Tick;
    logic        ServeKey;
    logic [10:0] PaddleLY;
    logic [10:0] PaddleRY;
    logic [10:0] BallX;
    logic [10:0] BallY;
    logic [3:0]  ScoreL;
    logic [3:0]  ScoreR;
    logic        PaddleReset;
    logic        GameOver;
    logic [2:0]  State;

    pong_ctrl dut (
        .GameClock   (GameClock),
        .Resetn      (Resetn),
        .Tick        (Tick),
        .ServeKey    (ServeKey),
        .PaddleLY    (PaddleLY),
        .PaddleRY    (PaddleRY),
        .BallX       (BallX),
        .BallY       (BallY),
        .ScoreL      (ScoreL),
        .ScoreR      (ScoreR),
        .PaddleReset (PaddleReset),
        .GameOver    (GameOver),
        .State       (State)
    );

    always #5 GameClock = ~GameClock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // model: phase 0 idle,1 serve,2 play,3 point,4 over
    int m_phase, m_x, m_y, m_vx, m_vy, m_sl, m_sr, m_cnt;
    int key_hist[3];

    task automatic model_reset();
        m_phase = 0;
        m_x = 632;
        m_y = 504;
        m_vx = 2;
        m_vy = 2;
        m_sl = 0;
        m_sr = 0;
        m_cnt = 0;
        for (int i = 0; i < 3; i++) key_hist[i] = 1;
    endtask

    function automatic bit overlaps(input int py);
        return (m_y + 16 > py) && (m_y < py + 200);
    endfunction

    task automatic model_step(input bit t, input bit k,
                              input int ly, input int ry);
        bit press;
        int nx, ny, nvx, nvy;
        // key seen low two edges after it was last seen high
        press = (key_hist[2] == 1) && (key_hist[1] == 0);
        key_hist[2] = key_hist[1];
        key_hist[1] = key_hist[0];
        key_hist[0] = k;
        case (m_phase)
            0: if (press) m_phase = 1;
            1: if (press) m_phase = 2;
            2: if (t) begin
                if (m_vx < 0 && m_x < 2) begin
                    m_sr = (m_sr < 7) ? m_sr + 1 : 7;
                    m_phase = 3; m_x = 632; m_y = 504;
                end else if (m_vx > 0 && m_x + 18 > 1280) begin
                    m_sl = (m_sl < 7) ? m_sl + 1 : 7;
                    m_phase = 3; m_x = 632; m_y = 504;
                end else begin
                    nx = m_x + m_vx; ny = m_y + m_vy;
                    nvx = m_vx; nvy = m_vy;
                    if (m_vx < 0 && m_x <= 56 && m_x + 16 > 40
                        && overlaps(ly)) begin
                        nx = 56; nvx = 2;
                    end
                    if (m_vx > 0 && m_x + 18 >= 1224 && m_x < 1240
                        && overlaps(ry)) begin
                        nx = 1208; nvx = -2;
                    end
                    if (m_vy > 0 && m_y + 18 >= 924) begin
                        ny = 908; nvy = -2;
                    end
                    if (m_vy < 0 && m_y <= 102) begin
                        ny = 100; nvy = 2;
                    end
                    m_x = nx; m_y = ny; m_vx = nvx; m_vy = nvy;
                end
            end
            3: if (t) begin
                if (m_cnt == 59) begin
                    m_cnt = 0;
                    m_phase = (m_sl == 7 || m_sr == 7) ? 4 : 1;
                end else begin
                    m_cnt++;
                end
            end
            4: if (press) begin
                m_sl = 0; m_sr = 0; m_vx = 2; m_phase = 1;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_all();
        chk("state", int'(State), m_phase);
        chk("ball_x", int'(BallX), m_x);
        chk("ball_y", int'(BallY), m_y);
        chk("score_l", int'(ScoreL), m_sl);
        chk("score_r", int'(ScoreR), m_sr);
        chk("paddle_reset", int'(PaddleReset),
            (m_phase == 0 || m_phase == 3 || m_phase == 4) ? 1 : 0);
        chk("game_over", int'(GameOver), (m_phase == 4) ? 1 : 0);
    endtask

    // called at a negedge; drives inputs for the coming posedge
    task automatic cycle(input bit t, input bit k,
                         input int ly, input int ry);
        Tick = t;
        ServeKey = k;
        PaddleLY = 11'(ly);
        PaddleRY = 11'(ry);
        model_step(t, k, ly, ry);
        @(negedge GameClock);
        check_all();
    endtask

    task automatic press_key(input bit t);
        for (int i = 0; i < 3; i++) cycle(t, 1'b0, 400, 400);
        for (int i = 0; i < 3; i++) cycle(t, 1'b1, 400, 400);
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        Tick = 1'b0;
        ServeKey = 1'b1;
        PaddleLY = 11'd400;
        PaddleRY = 11'd400;
        model_reset();
        repeat (2) @(negedge GameClock);
        check_all();
        Resetn = 1'b1;
    endtask

    task automatic random_play(input int ncyc);
        bit key, trk_l, trk_r, t;
        int ly, ry;
        key = 1'b1;
        trk_l = 1'b1;
        trk_r = 1'b1;
        for (int i = 0; i < ncyc && n_errors < 20; i++) begin
            if (m_x >= 600 && m_x <= 660) begin
                trk_l = ($urandom_range(0, 9) < 5);
                trk_r = ($urandom_range(0, 9) < 5);
            end
            ly = trk_l ? m_y - 50 : int'($urandom_range(0, 1800));
            ry = trk_r ? m_y - 50 : int'($urandom_range(0, 1800));
            if ($urandom_range(0, 39) == 0) key = ~key;
            t = ($urandom_range(0, 3) != 0);
            cycle(t, key, ly, ry);
        end
    endtask

    initial begin
        do_reset();

        // held key: exactly one advance
        for (int i = 0; i < 1000; i++) cycle(1'b0, 1'b0, 400, 400);
        chk("held_key_state", int'(State), 1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 400, 400);
        press_key(1'b0);
        chk("serve_to_play", int'(State), 2);
        chk("ball_still_x", int'(BallX), 632);

        random_play(40000);

        // async reset in the middle of play
        do_reset();
        press_key(1'b0);
        press_key(1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 400, 400);
        chk("in_play", int'(State), 2);
        #2 Resetn = 1'b0;
        #1;
        chk("arst_state", int'(State), 0);
        chk("arst_ball_x", int'(BallX), 632);
        chk("arst_ball_y", int'(BallY), 504);
        chk("arst_score_l", int'(ScoreL), 0);
        chk("arst_score_r", int'(ScoreR), 0);
        chk("arst_preset", int'(PaddleReset), 1);
        chk("arst_over", int'(GameOver), 0);
        model_reset();
        @(negedge GameClock);
        Resetn = 1'b1;

        random_play(20000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pong_ctrl.md
Name: pong_ctrl

Overview:
- Game sequencer for the two-player VGA pong design: owns ball position/direction, scores and the serve/point/game-over flow.
- Reads both paddle y positions, drives each paddle's preset input (PaddleReset) and feeds ball coordinates to the pixel renderer.
- Sits between the two paddle instances and the VGA drawing logic. Ball motion advances only on a one-cycle Tick strobe from the frame-rate divider.

Parameters:
- ScreenWidth, 1280, visible x extent in pixels
- yTopBar, 100, lower edge of the top wall
- yBottomBar, 924, upper edge of the bottom wall
- PaddleHeight, 200, paddle height (matches paddle instances)
- PaddleWidth, 16, paddle thickness in x
- xLeftPaddle, 40, left paddle left edge
- xRightPaddle, 1224, right paddle left edge
- BallSize, 16, ball side length (square)
- BallStep, 2, pixels moved per Tick on each axis
- WinScore, 7, score that ends the game
- PointDelay, 60, Ticks to hold in S_Point

Ports:
- GameClock  in  1  system clock, all state on posedge
- Resetn  in  1  asynchronous, active-low reset
- Tick  in  1  one-cycle motion strobe
- ServeKey  in  1  active-low push button, asynchronous to GameClock
- PaddleLY  in  11  left paddle top y
- PaddleRY  in  11  right paddle top y
- BallX  out  11  ball left x
- BallY  out  11  ball top y
- ScoreL  out  4  left player score
- ScoreR  out  4  right player score
- PaddleReset  out  1  high forces paddles to initial y
- GameOver  out  1  high in S_Over
- State  out  3  current state, debug/LED

Behaviour:
- Reset (Resetn low, asynchronous): State=S_Idle, BallX=(ScreenWidth-BallSize)/2=632, BallY=(yTopBar+yBottomBar-BallSize)/2=504, ScoreL=ScoreR=0, dx=+1 (right), dy=+1 (down), PaddleReset=1, GameOver=0, delay counter=0, serve synchronizer flops=1.
- ServeKey: 2-flop synchronizer, then falling-edge detect. ServePress is one cycle per press. A held key produces no further presses.
- States:
  - S_Idle (0): PaddleReset=1. On ServePress -> S_Serve.
  - S_Serve (1): PaddleReset=0. Ball held at centre. On ServePress -> S_Play.
  - S_Play (2): on each Tick, BallX += dx*BallStep and BallY += dy*BallStep, computed from pre-move values. With no Tick, ball holds.
  - S_Point (3): PaddleReset=1, ball at centre. Counter counts Ticks. When counter reaches PointDelay-1 on a Tick, clear counter -> S_Serve. If either score equals WinScore -> S_Over instead.
  - S_Over (4): GameOver=1, PaddleReset=1. On ServePress: clear scores, dx=+1 -> S_Serve.
- Wall bounce (on a Tick in S_Play):
  - dy=+1 and BallY+BallSize+BallStep >= yBottomBar: BallY=yBottomBar-BallSize, dy=-1.
  - dy=-1 and BallY <= yTopBar+BallStep: BallY=yTopBar, dy=+1.
- Paddle hit, left: dx=-1, BallX <= xLeftPaddle+PaddleWidth, BallX+BallSize > xLeftPaddle, and y-overlap (BallY+BallSize > PaddleLY && BallY < PaddleLY+PaddleHeight). Result: BallX=xLeftPaddle+PaddleWidth, dx=+1.
- Paddle hit, right: mirror of left using xRightPaddle and PaddleRY. Result: BallX=xRightPaddle-BallSize, dx=-1.
- Miss:
  - dx=-1 and BallX < BallStep: ScoreR+=1, dx=-1 (serve toward loser), -> S_Point.
  - dx=+1 and BallX+BallSize+BallStep > ScreenWidth: ScoreL+=1, dx=+1, -> S_Point.
- Priority within one Tick: miss > paddle hit > wall bounce. Wall bounce and paddle hit may both apply in the same Tick (corner); both direction flips happen.
- Scores saturate at WinScore. Entering S_Point re-centres the ball. dy is kept across points.
- All comparisons are unsigned, done at 12 bits to avoid overflow. Outputs are registered, so a state change is visible one cycle after the causing edge.
- Resetn asserted mid-game returns everything to reset values immediately.
- Undefined State encodings -> S_Idle.

Decomposition:
- Shared package/include: state encodings S_Idle..S_Over, screen geometry constants (ScreenWidth, yTopBar, yBottomBar, PaddleHeight). Paddle instances and pong_ctrl share one set of geometry values.
- One sub-module: key_sync_edge (2-flop sync + falling-edge pulse), reused for ServeKey.

Test Plan:
- Reset then ServeKey pressed twice with no Tick -> State 0->1->2; ball stays (632,504); PaddleReset 1->0.
- S_Play, PaddleRY=400, ball forced to BallX=1206, BallY=450, dx=+1, then Tick -> BallX=1208, dx=-1; scores unchanged.
- S_Play, PaddleRY=100, ball dx=+1 travelling at BallY=800 -> ScoreL=1, State=3, PaddleReset=1. After 60 Ticks -> State=1, ball (632,504), dx=+1.
- Ball at BallY=906, dy=+1, Tick -> BallY=908, dy=-1. Ball at BallY=101, dy=-1, Tick -> BallY=100, dy=+1.
- ScoreL=6, left scores -> ScoreL=7. After PointDelay -> State=4, GameOver=1. ServePress -> scores 0, State=1.
- ServeKey held low for 1000 cycles -> exactly one state advance. Resetn pulsed low mid-S_Play -> all outputs at reset values within the same cycle.
